program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the CPU's instruction-load interface.
- Receives a framed byte stream from a host over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word into instruction memory at sequential addresses from 0.
- Holds the CPU in reset during the load and releases it once the image is complete.

Parameters:
- ADDR_W, 16: width of load_addr.
- MAX_WORDS, 256: instruction memory depth; maximum legal frame length.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  host byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle.
- instruction_out  out  16  word to be written; drives the CPU's instruction_in.
- load_addr  out  ADDR_W  instruction memory write address.
- load_we  out  1  one-cycle write strobe; drives load_instruction.
- cpu_hold  out  1  active-high hold; drives the CPU's pc_reset.
- done  out  1  image loaded, CPU running.
- error  out  1  frame rejected.

Behaviour:
- Handshake:
  - A byte is accepted only on a rising edge where in_valid and in_ready are both 1.
  - in_ready = 0 only in WRITE; 1 in every other state.
  - in_data is ignored when in_valid = 0.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then LEN words, each sent high byte then low byte. A checksum byte follows only when the optional feature is compiled in.
- Reset values: in_ready=1, instruction_out=0, load_addr=0, load_we=0, cpu_hold=1, done=0, error=0. State = IDLE, word index = 0.
- States and transitions:
  - IDLE: accepted SYNC_BYTE -> LEN_HI. Any other accepted byte is dropped.
  - LEN_HI: latch length[15:8] -> LEN_LO.
  - LEN_LO: latch length[7:0].
    - length==0 or length>MAX_WORDS -> ERROR.
    - Otherwise clear index -> DATA_HI.
  - DATA_HI: latch word[15:8] -> DATA_LO.
  - DATA_LO: latch word[7:0] -> WRITE.
  - WRITE: lasts exactly one cycle. load_we=1, load_addr=index, instruction_out=assembled word. Index increments.
    - New index == length -> RUN (or CHK if the feature is compiled in).
    - Otherwise -> DATA_HI.
  - RUN: cpu_hold=0 and done=1, both registered, from the first cycle in RUN.
    - Accepted SYNC_BYTE -> LEN_HI: cpu_hold=1 and done=0 on the next cycle (reload).
    - Other bytes are dropped.
  - ERROR: error=1, cpu_hold=1.
    - Accepted SYNC_BYTE -> LEN_HI and error clears.
    - Other bytes are dropped.
- Latency: load_we pulses in the cycle after the low byte is accepted.
- cpu_hold stays 1 in every state except RUN.
- Index width is ADDR_W; it never wraps because length ≤ MAX_WORDS.
- A SYNC_BYTE value received inside the length or data fields is treated as data, not resynchronisation.
- reset_n low at any time, including mid-frame: every output and the state return to reset values immediately. A partially received word is discarded; words already written stay in memory.
- instruction_out and load_addr hold their last values outside WRITE.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (length bytes excluded) is kept, cleared on SYNC_BYTE.
  - After the last WRITE, go to CHK and accept one byte.
  - Byte equals the XOR -> RUN. Mismatch -> ERROR, cpu_hold stays 1.
- Undefined: no CHK state; the last WRITE goes directly to RUN.

Test Plan:
- Basic load: after reset, stream A5 00 02 12 34 AB CD back-to-back -> load_we pulses with addr0=0x1234 and addr1=0xABCD; cpu_hold=0 and done=1 on the cycle after the second pulse; exactly 2 strobes.
- Gapped stream: same frame with in_valid low 3 cycles between bytes -> identical writes; no extra strobes; in_ready=0 only in WRITE cycles.
- Bad length: frames A5 00 00 and A5 01 01 -> error=1, cpu_hold=1, no load_we. A following valid frame A5 00 01 00 0F -> error=0, addr0=0x000F, done=1.
- Ignored bytes and reload: bytes 00 and 5A in IDLE -> no state change. After done, send A5 00 01 FF FF -> cpu_hold=1 next cycle, then write addr0=0xFFFF and done=1 again.
- Mid-frame reset: after the first WRITE of a 2-word frame, pulse reset_n low -> all outputs at reset values asynchronously; the remaining bytes are ignored until the next A5.
- Checksum (PROGRAM_LOADER_CHECKSUM_EN defined): A5 00 02 12 34 AB CD 40 -> done=1. Same frame with final byte 41 -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/program_loader.sv
// Host byte-stream loader: frames SYNC/LEN_HI/LEN_LO/words into instruction memory and holds the CPU until done.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int             ADDR_W    = 16,
   parameter int             MAX_WORDS = 256,
   parameter logic [7:0]     SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [15:0]       instruction_out,
   output logic [ADDR_W-1:0] load_addr,
   output logic              load_we,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, RUN, ERROR, CHK} state_t;
`else
   typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, RUN, ERROR} state_t;
`endif

   localparam int          CW      = (ADDR_W > 16) ? ADDR_W : 16;
   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t              state, next_state;
   logic [7:0]          len_hi;
   logic [15:0]         length;
   logic [ADDR_W-1:0]   idx;
   logic [ADDR_W-1:0]   idx_next;
   logic [7:0]          word_hi;
   logic [15:0]         len_new;
   logic                accept;
   logic                len_bad;
   logic                last_word;
   logic                sync_seen;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]          csum;
`endif

   assign in_ready  = (state != WRITE);
   assign accept    = in_valid & in_ready;
   assign len_new   = {len_hi, in_data};
   assign len_bad   = (len_new == 16'd0) || ({1'b0, len_new} > MAX_LEN);
   assign idx_next  = idx + ADDR_W'(1);
   assign last_word = (CW'(idx_next) == CW'(length));
   // Only the waiting states resynchronise; a SYNC value inside a frame is payload.
   assign sync_seen = accept && (in_data == SYNC_BYTE) &&
                      ((state == IDLE) || (state == RUN) || (state == ERROR));

   always_comb begin
      next_state = state;
      case (state)
         IDLE, RUN, ERROR: if (sync_seen) next_state = LEN_HI;
         LEN_HI:  if (accept) next_state = LEN_LO;
         LEN_LO:  if (accept) next_state = len_bad ? ERROR : DATA_HI;
         DATA_HI: if (accept) next_state = DATA_LO;
         DATA_LO: if (accept) next_state = WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         WRITE:   next_state = last_word ? CHK : DATA_HI;
         CHK:     if (accept) next_state = (in_data == csum) ? RUN : ERROR;
`else
         WRITE:   next_state = last_word ? RUN : DATA_HI;
`endif
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         len_hi          <= '0;
         length          <= '0;
         idx             <= '0;
         word_hi         <= '0;
         instruction_out <= '0;
         load_addr       <= '0;
         load_we         <= 1'b0;
         cpu_hold        <= 1'b1;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         state    <= next_state;
         load_we  <= 1'b0;
         // Status flags follow the state being entered so they are valid from its first cycle.
         cpu_hold <= (next_state != RUN);
         done     <= (next_state == RUN);
         error    <= (next_state == ERROR);
         if (accept) begin
            case (state)
               LEN_HI:  len_hi <= in_data;
               LEN_LO:  begin
                  length <= len_new;
                  idx    <= '0;
               end
               DATA_HI: word_hi <= in_data;
               DATA_LO: begin
                  instruction_out <= {word_hi, in_data};
                  load_addr       <= idx;
                  load_we         <= 1'b1;
               end
               default: ;
            endcase
         end
         if (state == WRITE) idx <= idx_next;
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         csum <= '0;
      else if (sync_seen)
         csum <= '0;
      else if (accept && ((state == DATA_HI) || (state == DATA_LO)))
         csum <= csum ^ in_data;
   end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader; expected writes come from the frames it builds.
module tb_program_loader;
   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, load_we, cpu_hold, done, error;
   logic [15:0] instruction_out;
   logic [15:0] load_addr;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] wr_q[$];
   logic [15:0] words[$];

   always #5 clk = ~clk;

   program_loader dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .instruction_out(instruction_out), .load_addr(load_addr),
      .load_we(load_we), .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   // Write monitor, plus the invariant that in_ready drops exactly in the write cycle.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && load_we === 1'b1) wr_q.push_back({load_addr, instruction_out});
      if (reset_n === 1'b1) begin
         checks++;
         if (in_ready !== ~load_we) begin
            failures++;
            $display("FAIL ready_vs_we in_ready=%b load_we=%b required in_ready=~load_we", in_ready, load_we);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      w = 0;
      while (in_ready !== 1'b1 && w < 8) begin
         @(negedge clk);
         w++;
      end
      if (w >= 8) begin
         failures++;
         $display("FAIL handshake_timeout in_ready=%b required=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
   endtask

   // Sends a frame with the given length field; payload only when the length is legal.
   task automatic send_frame(input logic [15:0] len, input int gap_max, input bit bad_sum);
      logic [7:0] x;
      x = 8'h00;
      send_byte(8'hA5, $urandom_range(gap_max, 0));
      send_byte(len[15:8], $urandom_range(gap_max, 0));
      send_byte(len[7:0], $urandom_range(gap_max, 0));
      if (len != 16'd0 && len <= 16'd256) begin
         foreach (words[i]) begin
            send_byte(words[i][15:8], $urandom_range(gap_max, 0));
            send_byte(words[i][7:0], $urandom_range(gap_max, 0));
            x = x ^ words[i][15:8] ^ words[i][7:0];
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         send_byte(x ^ {7'd0, bad_sum}, $urandom_range(gap_max, 0));
`else
         if (bad_sum) x = 8'h00;
`endif
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(1);
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      checks += 7;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
      if (instruction_out !== 16'h0) begin failures++; $display("FAIL rst_instr got=%h want=0000", instruction_out); end
      if (load_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h want=0000", load_addr); end
      if (load_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b want=0", load_we); end
      if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_hold got=%b want=1", cpu_hold); end
      if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done); end
      if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b want=0", error); end
      idle(2);
      reset_n = 1'b1;
      idle(2);
      checks++;
      if (cpu_hold !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL rst_idle hold=%b done=%b want hold=1 done=0", cpu_hold, done);
      end
   endtask

   task automatic test_basic();
      logic [7:0] b[7];
      b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      wr_q.delete();
      foreach (b[i]) send_byte(b[i], 0);
      checks++;
      if (load_we !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL basic_last_write we=%b hold=%b done=%b want 1 1 0", load_we, cpu_hold, done);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      idle(1);
      checks++;
      if (done !== 1'b0 || cpu_hold !== 1'b1) begin
         failures++; $display("FAIL basic_chk_wait done=%b hold=%b want 0 1", done, cpu_hold);
      end
      send_byte(8'h40, 0);
`else
      idle(1);
`endif
      checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
         failures++; $display("FAIL basic_run done=%b hold=%b err=%b want 1 0 0", done, cpu_hold, error);
      end
      idle(3);
      checks++;
      if (wr_q.size() != 2) begin
         failures++; $display("FAIL basic_count got=%0d want=2", wr_q.size());
      end else begin
         checks += 2;
         if (wr_q[0] !== 32'h0000_1234) begin failures++; $display("FAIL basic_w0 got=%h want=00001234", wr_q[0]); end
         if (wr_q[1] !== 32'h0001_ABCD) begin failures++; $display("FAIL basic_w1 got=%h want=0001abcd", wr_q[1]); end
      end
   endtask

   task automatic test_gapped();
      for (int k = 0; k < 5; k++) begin
         wr_q.delete();
         fill_words(int'($urandom_range(8, 1)));
         send_frame(16'(words.size()), 3, 1'b0);
         idle(3);
         checks++;
         if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            failures++; $display("FAIL gapped_run k=%0d done=%b hold=%b err=%b want 1 0 0", k, done, cpu_hold, error);
         end
         checks++;
         if (wr_q.size() != words.size()) begin
            failures++; $display("FAIL gapped_count k=%0d got=%0d want=%0d", k, wr_q.size(), words.size());
         end else begin
            foreach (words[i]) begin
               checks++;
               if (wr_q[i] !== {16'(i), words[i]}) begin
                  failures++; $display("FAIL gapped_word k=%0d i=%0d got=%h want=%h", k, i, wr_q[i], {16'(i), words[i]});
               end
            end
         end
      end
   endtask

   task automatic test_bad_length();
      logic [15:0] lens[3];
      lens = '{16'd0, 16'd257, 16'($urandom_range(65535, 258))};
      foreach (lens[j]) begin
         wr_q.delete();
         send_frame(lens[j], 2, 1'b0);
         send_byte(8'h00, 0);
         idle(2);
         checks++;
         if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL badlen len=%0d err=%b hold=%b done=%b writes=%0d want 1 1 0 0", lens[j], error, cpu_hold, done, wr_q.size());
         end
      end
      wr_q.delete();
      words.delete();
      words.push_back(16'h000F);
      send_frame(16'd1, 0, 1'b0);
      idle(2);
      checks++;
      if (error !== 1'b0 || done !== 1'b1 || wr_q.size() != 1) begin
         failures++; $display("FAIL badlen_recover err=%b done=%b writes=%0d want 0 1 1", error, done, wr_q.size());
      end else begin
         checks++;
         if (wr_q[0] !== 32'h0000_000F) begin failures++; $display("FAIL badlen_w0 got=%h want=0000000f", wr_q[0]); end
      end
      // Largest legal frame fills the whole memory.
      wr_q.delete();
      fill_words(256);
      send_frame(16'd256, 0, 1'b0);
      idle(2);
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || wr_q.size() != 256) begin
         failures++; $display("FAIL maxlen done=%b err=%b writes=%0d want 1 0 256", done, error, wr_q.size());
      end else begin
         foreach (words[i]) begin
            checks++;
            if (wr_q[i] !== {16'(i), words[i]}) begin
               failures++; $display("FAIL maxlen_word i=%0d got=%h want=%h", i, wr_q[i], {16'(i), words[i]});
            end
         end
      end
   endtask

   task automatic test_ignored_reload();
      reset_dut();
      wr_q.delete();
      send_byte(8'h00, 0);
      send_byte(8'h5A, 1);
      send_byte(8'hFF, 0);
      idle(2);
      checks++;
      if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || wr_q.size() != 0) begin
         failures++; $display("FAIL idle_drop hold=%b done=%b err=%b writes=%0d want 1 0 0 0", cpu_hold, done, error, wr_q.size());
      end
      // SYNC values inside the frame are payload.
      words.delete();
      words.push_back(16'hA5A5);
      words.push_back(16'h00A5);
      send_frame(16'd2, 1, 1'b0);
      idle(2);
      checks++;
      if (done !== 1'b1 || wr_q.size() != 2) begin
         failures++; $display("FAIL sync_payload done=%b writes=%0d want 1 2", done, wr_q.size());
      end else begin
         checks++;
         if (wr_q[0] !== 32'h0000_A5A5 || wr_q[1] !== 32'h0001_00A5) begin
            failures++; $display("FAIL sync_payload_words got=%h,%h want=0000a5a5,000100a5", wr_q[0], wr_q[1]);
         end
      end
      wr_q.delete();
      send_byte(8'h00, 0);
      send_byte(8'h5A, 0);
      idle(1);
      checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || wr_q.size() != 0) begin
         failures++; $display("FAIL run_drop done=%b hold=%b writes=%0d want 1 0 0", done, cpu_hold, wr_q.size());
      end
      send_byte(8'hA5, 0);
      checks++;
      if (cpu_hold !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL reload_hold hold=%b done=%b want 1 0", cpu_hold, done);
      end
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hFF, 0);
      send_byte(8'hFF, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h00, 0);
`endif
      idle(2);
      checks++;
      if (done !== 1'b1 || wr_q.size() != 1) begin
         failures++; $display("FAIL reload_done done=%b writes=%0d want 1 1", done, wr_q.size());
      end else begin
         checks++;
         if (wr_q[0] !== 32'h0000_FFFF) begin failures++; $display("FAIL reload_w0 got=%h want=0000ffff", wr_q[0]); end
      end
   endtask

   task automatic test_midframe_reset();
      logic [7:0] b[5];
      b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
      wr_q.delete();
      foreach (b[i]) send_byte(b[i], 0);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || instruction_out !== 16'h0 || load_addr !== 16'h0 || load_we !== 1'b0 ||
          cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outputs rdy=%b instr=%h addr=%h we=%b hold=%b done=%b err=%b want 1 0000 0000 0 1 0 0",
                  in_ready, instruction_out, load_addr, load_we, cpu_hold, done, error);
      end
      @(negedge clk);
      reset_n = 1'b1;
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      idle(3);
      checks++;
      if (wr_q.size() != 1 || done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1) begin
         failures++; $display("FAIL midrst_drop writes=%0d done=%b err=%b hold=%b want 1 0 0 1", wr_q.size(), done, error, cpu_hold);
      end
      wr_q.delete();
      fill_words(3);
      send_frame(16'd3, 1, 1'b0);
      idle(2);
      checks++;
      if (done !== 1'b1 || wr_q.size() != 3) begin
         failures++; $display("FAIL midrst_reload done=%b writes=%0d want 1 3", done, wr_q.size());
      end else begin
         foreach (words[i]) begin
            checks++;
            if (wr_q[i] !== {16'(i), words[i]}) begin
               failures++; $display("FAIL midrst_word i=%0d got=%h want=%h", i, wr_q[i], {16'(i), words[i]});
            end
         end
      end
   endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] b[7];
      b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      foreach (b[i]) send_byte(b[i], 0);
      send_byte(8'h40, 0);
      idle(1);
      checks++;
      if (done !== 1'b1 || error !== 1'b0) begin
         failures++; $display("FAIL csum_good done=%b err=%b want 1 0", done, error);
      end
      foreach (b[i]) send_byte(b[i], 0);
      send_byte(8'h41, 0);
      idle(1);
      checks++;
      if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL csum_bad err=%b hold=%b done=%b want 1 1 0", error, cpu_hold, done);
      end
      for (int k = 0; k < 4; k++) begin
         bit bad;
         bad = 1'($urandom_range(1, 0));
         fill_words(int'($urandom_range(6, 1)));
         send_frame(16'(words.size()), 2, bad);
         idle(2);
         checks++;
         if (error !== bad || done !== !bad) begin
            failures++; $display("FAIL csum_rand k=%0d err=%b done=%b want err=%b", k, error, done, bad);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_bad_length();
      test_ignored_reload();
      test_midframe_reset();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
